// File: rtl/axi_stream_master_pkg.sv
// rtl/axi_stream_master_pkg.sv - shared widths for the word-to-byte stream serializer
package axi_stream_master_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_BEATS  = 8;
  localparam int WORD_W     = DEF_DATA_W * DEF_BEATS;
  localparam int CNT_W      = $clog2(DEF_BEATS + 1);

endpackage

// File: rtl/axi_stream_master.sv
// rtl/axi_stream_master.sv - serializes a loaded word into LSB-first stream beats (optional AXIS_MASTER_DROP_FLAG_EN)
module axi_stream_master
  import axi_stream_master_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W*BEATS-1:0]  data_in,
  input  logic                     we,
  output logic [DATA_W-1:0]        data,
  output logic                     valid,
  output logic                     last,
  input  logic                     ready
`ifdef AXIS_MASTER_DROP_FLAG_EN
  ,
  output logic                     wr_dropped,
  output logic [7:0]               drop_count
`endif
);

  localparam int WORD_BITS = DATA_W * BEATS;
  localparam int CNT_BITS  = $clog2(BEATS + 1);

  logic [WORD_BITS-1:0] data_buff;
  logic [CNT_BITS-1:0]  buff_count;

  // Outputs come straight from state so ready/we never reach them combinationally.
  assign data  = data_buff[DATA_W-1:0];
  assign valid = (buff_count != '0);
  assign last  = (buff_count == CNT_BITS'(1));

  // Load when idle, otherwise shift one beat out per handshake; busy writes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_buff  <= '0;
      buff_count <= '0;
    end else if (buff_count == '0) begin
      if (we) begin
        data_buff  <= data_in;
        buff_count <= CNT_BITS'(BEATS);
      end
    end else if (ready) begin
      data_buff  <= data_buff >> DATA_W;
      buff_count <= buff_count - CNT_BITS'(1);
    end
  end

`ifdef AXIS_MASTER_DROP_FLAG_EN
  // Record writes that arrived while a word was still in flight; flag is sticky, count saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_dropped <= 1'b0;
      drop_count <= '0;
    end else if (we && (buff_count != '0)) begin
      wr_dropped <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_master.sv
// tb/tb_axi_stream_master.sv - scoreboard bench for axi_stream_master
module tb_axi_stream_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] data_in;
  logic        we;
  logic [7:0]  data;
  logic        valid;
  logic        last;
  logic        ready;
`ifdef AXIS_MASTER_DROP_FLAG_EN
  logic        wr_dropped;
  logic [7:0]  drop_count;
`endif

  axi_stream_master dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .we      (we),
    .data    (data),
    .valid   (valid),
    .last    (last),
    .ready   (ready)
`ifdef AXIS_MASTER_DROP_FLAG_EN
    ,
    .wr_dropped (wr_dropped),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] byte_val;
    logic       is_last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;
  int    drop_exp = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor and reference model: a word accepted while nothing is pending becomes 8 queued bytes.
  always @(negedge clk) begin
    bit    idle;
    beat_t b;
    if (!reset_n) begin
      exp_q.delete();
      drop_exp = 0;
      chk(valid == 1'b0, "reset_valid", 64'(valid), 64'd0);
      chk(data == 8'h00, "reset_data", 64'(data), 64'd0);
      chk(last == 1'b0, "reset_last", 64'(last), 64'd0);
`ifdef AXIS_MASTER_DROP_FLAG_EN
      chk(wr_dropped == 1'b0, "reset_wr_dropped", 64'(wr_dropped), 64'd0);
      chk(drop_count == 8'd0, "reset_drop_count", 64'(drop_count), 64'd0);
`endif
    end else begin
      idle = (exp_q.size() == 0);
      chk(valid == !idle, "valid", 64'(valid), 64'(!idle));
      if (idle) begin
        chk(data == 8'h00, "idle_data", 64'(data), 64'd0);
        chk(last == 1'b0, "idle_last", 64'(last), 64'd0);
      end
`ifdef AXIS_MASTER_DROP_FLAG_EN
      chk(wr_dropped == (drop_exp != 0), "wr_dropped", 64'(wr_dropped), 64'(drop_exp != 0));
      chk(drop_count == 8'(drop_exp), "drop_count", 64'(drop_count), 64'(drop_exp));
`endif
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "extra_beat", 64'(data), 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk(data == b.byte_val, "beat_data", 64'(data), 64'(b.byte_val));
          chk(last == b.is_last, "beat_last", 64'(last), 64'(b.is_last));
        end
      end
      if (we) begin
        if (idle) begin
          for (int i = 0; i < 8; i++) begin
            b.byte_val = data_in[8*i +: 8];
            b.is_last  = (i == 7);
            exp_q.push_back(b);
          end
        end else if (drop_exp < 255) begin
          drop_exp++;
        end
      end
    end
  end

  task automatic step(input bit w, input logic [63:0] d, input bit r);
    @(posedge clk);
    #1;
    we      = w;
    data_in = d;
    ready   = r;
  endtask

  localparam logic [63:0] WORD_A = 64'h0807060504030201;
  localparam logic [63:0] WORD_B = 64'hF1E2D3C4B5A69788;

  initial begin
    reset_n = 1'b0;
    we      = 1'b0;
    ready   = 1'b0;
    data_in = '0;
    repeat (3) step(1'b0, 64'd0, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Continuous drain
    step(1'b1, WORD_A, 1'b1);
    repeat (10) step(1'b0, 64'd0, 1'b1);

    // Backpressure after three beats
    step(1'b1, WORD_A, 1'b1);
    repeat (3) step(1'b0, 64'd0, 1'b1);
    repeat (5) step(1'b0, 64'd0, 1'b0);
    repeat (8) step(1'b0, 64'd0, 1'b1);

    // Write while busy is dropped
    step(1'b1, WORD_A, 1'b1);
    repeat (2) step(1'b0, 64'd0, 1'b1);
    step(1'b1, WORD_B, 1'b1);
    repeat (8) step(1'b0, 64'd0, 1'b1);

    // Asynchronous reset mid-word
    step(1'b1, WORD_B, 1'b1);
    repeat (3) step(1'b0, 64'd0, 1'b1);
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) step(1'b0, 64'd0, 1'b1);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) step(1'b0, 64'd0, 1'b1);

    // Back-to-back: write held high, second word taken once idle
    step(1'b1, WORD_A, 1'b1);
    repeat (9) step(1'b1, WORD_B, 1'b1);
    repeat (10) step(1'b0, 64'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) == 0), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    // Bounded drain
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 64'd0, 1'b1);
    end
    @(negedge clk);
    chk(exp_q.size() == 0, "drain_complete", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
